// File: rtl/my_pkg.sv
// Shared types for the single-port memory arbiter.
//   arbSrc_e   : requester identity; also the encoding of timeout_src_o
//   arbState_e : arbiter FSM states
//   GNT_*      : bit positions in the one-hot grant vector
package my_pkg;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_FETCH = 2'd1,
        SRC_LOAD  = 2'd2,
        SRC_STORE = 2'd3
    } arbSrc_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arbState_e;

    localparam int GNT_FETCH = 0;
    localparam int GNT_LOAD  = 1;
    localparam int GNT_STORE = 2;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational priority picker for the memory port.
//   i_fetch_req/i_load_req/i_store_req : live request lines
//   i_starve                           : fetch has lost too often, promote it over load
//   o_gnt                              : one-hot grant, bit order per GNT_* in my_pkg
//   o_src                              : granted source as arbSrc_e (SRC_NONE if none)
module mem_arb_select
    import my_pkg::*;
(
    input  logic       i_fetch_req,
    input  logic       i_load_req,
    input  logic       i_store_req,
    input  logic       i_starve,
    output logic [2:0] o_gnt,
    output arbSrc_e    o_src
);

    always_comb begin
        o_gnt = 3'b000;
        o_src = SRC_NONE;
        // Store always first: it comes from retire and is already committed.
        if (i_store_req) begin
            o_gnt[GNT_STORE] = 1'b1;
            o_src            = SRC_STORE;
        end else if (i_fetch_req && i_starve) begin
            o_gnt[GNT_FETCH] = 1'b1;
            o_src            = SRC_FETCH;
        end else if (i_load_req) begin
            o_gnt[GNT_LOAD]  = 1'b1;
            o_src            = SRC_LOAD;
        end else if (i_fetch_req) begin
            o_gnt[GNT_FETCH] = 1'b1;
            o_src            = SRC_FETCH;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port among instruction fetch, data load and
// data store. One transaction in flight at a time: grant in IDLE, drive the
// latched request in BUSY until mem_ready_i or a bounded wait expires.
//   clk, reset                 : clock, synchronous active-high reset
//   fetch_* / load_* / store_* : per-requester req, address, grant and response
//   mem_*                      : external memory port (req held for the whole wait)
//   timeout_o, timeout_src_o   : one-cycle abort pulse and aborted source
module mem_port_arbiter
    import my_pkg::*;
#(
    parameter int unsigned MAX_WAIT     = 15,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_gnt_o,
    output logic        fetch_rvalid_o,
    output logic [31:0] fetch_rdata_o,
    input  logic        load_req_i,
    input  logic [31:0] load_addr_i,
    output logic        load_gnt_o,
    output logic        load_rvalid_o,
    output logic [31:0] load_rdata_o,
    input  logic        store_req_i,
    input  logic [31:0] store_addr_i,
    input  logic [3:0]  store_we_i,
    input  logic [31:0] store_data_i,
    output logic        store_gnt_o,
    output logic        store_done_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic        timeout_o,
    output logic [1:0]  timeout_src_o
);

    localparam int SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0]    WAIT_MAX   = 8'(MAX_WAIT);

    arbState_e     r_state, w_state_nxt;
    arbSrc_e       r_src;
    logic [31:0]   r_addr;
    logic [3:0]    r_we;
    logic [31:0]   r_wdata;
    logic [7:0]    r_wait_cnt;
    logic [SW-1:0] r_starve_cnt;
    logic          r_fetch_rvalid, r_load_rvalid, r_store_done;
    logic [31:0]   r_fetch_rdata, r_load_rdata;
    logic          r_timeout;
    arbSrc_e       r_timeout_src;

    logic [2:0]    w_sel_gnt;
    arbSrc_e       w_sel_src;
    logic [2:0]    w_gnt;
    logic          w_done, w_abort;
    logic [31:0]   w_rsp_data;

    mem_arb_select u_sel (
        .i_fetch_req (fetch_req_i),
        .i_load_req  (load_req_i),
        .i_store_req (store_req_i),
        .i_starve    (r_starve_cnt == STARVE_MAX),
        .o_gnt       (w_sel_gnt),
        .o_src       (w_sel_src)
    );

    // Grants only exist in IDLE; the port is single-outstanding.
    assign w_gnt = (r_state == IDLE) ? w_sel_gnt : 3'b000;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: if (|w_sel_gnt) w_state_nxt = BUSY;
            BUSY: begin
                // Ready takes precedence over an expiring wait in the same cycle.
                if (mem_ready_i) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_wait_cnt == WAIT_MAX) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_rsp_data = w_done ? mem_rdata_i : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src          <= SRC_NONE;
            r_addr         <= '0;
            r_we           <= '0;
            r_wdata        <= '0;
            r_wait_cnt     <= '0;
            r_starve_cnt   <= '0;
            r_fetch_rvalid <= 1'b0;
            r_load_rvalid  <= 1'b0;
            r_store_done   <= 1'b0;
            r_fetch_rdata  <= '0;
            r_load_rdata   <= '0;
            r_timeout      <= 1'b0;
            r_timeout_src  <= SRC_NONE;
        end else begin
            r_fetch_rvalid <= 1'b0;
            r_load_rvalid  <= 1'b0;
            r_store_done   <= 1'b0;
            r_timeout      <= 1'b0;
            r_timeout_src  <= SRC_NONE;

            if (|w_gnt) begin
                r_src      <= w_sel_src;
                r_wait_cnt <= '0;
                if (w_gnt[GNT_STORE]) begin
                    r_addr  <= store_addr_i;
                    r_we    <= store_we_i;
                    r_wdata <= store_data_i;
                end else begin
                    r_addr  <= w_gnt[GNT_LOAD] ? load_addr_i : fetch_addr_i;
                    r_we    <= 4'b0000;
                    r_wdata <= 32'd0;
                end
            end else if (r_state == BUSY && !w_done && !w_abort) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            // Fetch loses only when someone else wins while it is asking.
            if (w_gnt[GNT_FETCH])
                r_starve_cnt <= '0;
            else if ((w_gnt[GNT_LOAD] || w_gnt[GNT_STORE]) && fetch_req_i &&
                     r_starve_cnt != STARVE_MAX)
                r_starve_cnt <= r_starve_cnt + 1'b1;

            if (w_done || w_abort) begin
                case (r_src)
                    SRC_FETCH: begin
                        r_fetch_rvalid <= 1'b1;
                        r_fetch_rdata  <= w_rsp_data;
                    end
                    SRC_LOAD: begin
                        r_load_rvalid <= 1'b1;
                        r_load_rdata  <= w_rsp_data;
                    end
                    SRC_STORE: r_store_done <= 1'b1;
                    default: ;
                endcase
                if (w_abort) begin
                    r_timeout     <= 1'b1;
                    r_timeout_src <= r_src;
                end
            end
        end
    end

    assign fetch_gnt_o    = w_gnt[GNT_FETCH];
    assign load_gnt_o     = w_gnt[GNT_LOAD];
    assign store_gnt_o    = w_gnt[GNT_STORE];
    assign fetch_rvalid_o = r_fetch_rvalid;
    assign fetch_rdata_o  = r_fetch_rdata;
    assign load_rvalid_o  = r_load_rvalid;
    assign load_rdata_o   = r_load_rdata;
    assign store_done_o   = r_store_done;

    // Port is quiet outside BUSY so stale latches never reach memory.
    assign mem_req_o   = (r_state == BUSY);
    assign mem_addr_o  = mem_req_o ? r_addr  : 32'd0;
    assign mem_we_o    = mem_req_o ? r_we    : 4'b0000;
    assign mem_wdata_o = mem_req_o ? r_wdata : 32'd0;

    assign timeout_o     = r_timeout;
    assign timeout_src_o = r_timeout_src;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req_i, load_req_i, store_req_i;
    logic [31:0] fetch_addr_i, load_addr_i, store_addr_i, store_data_i;
    logic [3:0]  store_we_i;
    logic        fetch_gnt_o, fetch_rvalid_o, load_gnt_o, load_rvalid_o;
    logic        store_gnt_o, store_done_o;
    logic [31:0] fetch_rdata_o, load_rdata_o;
    logic        mem_req_o, mem_ready_i, timeout_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_we_o;
    logic [1:0]  timeout_src_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_WAIT(15), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
        .fetch_gnt_o(fetch_gnt_o), .fetch_rvalid_o(fetch_rvalid_o),
        .fetch_rdata_o(fetch_rdata_o),
        .load_req_i(load_req_i), .load_addr_i(load_addr_i),
        .load_gnt_o(load_gnt_o), .load_rvalid_o(load_rvalid_o),
        .load_rdata_o(load_rdata_o),
        .store_req_i(store_req_i), .store_addr_i(store_addr_i),
        .store_we_i(store_we_i), .store_data_i(store_data_i),
        .store_gnt_o(store_gnt_o), .store_done_o(store_done_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
        .mem_rdata_i(mem_rdata_i),
        .timeout_o(timeout_o), .timeout_src_o(timeout_src_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Advance one cycle; inputs are then driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational grants settle after inputs change.
    task automatic settle();
        #1;
    endtask

    initial begin
        int cnt;
        int pulses;
        reset = 1'b1;
        fetch_req_i = 0; load_req_i = 0; store_req_i = 0;
        fetch_addr_i = 0; load_addr_i = 0; store_addr_i = 0;
        store_data_i = 0; store_we_i = 0;
        mem_ready_i = 0; mem_rdata_i = 0;
        tick(); tick();
        reset = 1'b0;
        settle();
        chk("rst_mem_req",  {31'd0, mem_req_o}, 0);
        chk("rst_gnts",     {29'd0, store_gnt_o, load_gnt_o, fetch_gnt_o}, 0);
        chk("rst_timeout",  {29'd0, timeout_o, timeout_src_o}, 0);
        chk("rst_rdata",    fetch_rdata_o | load_rdata_o, 0);

        // 1: single load, zero-wait memory
        load_req_i = 1; load_addr_i = 32'h100; settle();
        chk("t1_load_gnt", {31'd0, load_gnt_o}, 1);
        tick();
        load_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'hDEADBEEF; settle();
        chk("t1_mem_req",  {31'd0, mem_req_o}, 1);
        chk("t1_mem_addr", mem_addr_o, 32'h100);
        chk("t1_mem_we",   {28'd0, mem_we_o}, 0);
        chk("t1_rv_early", {31'd0, load_rvalid_o}, 0);
        tick();
        mem_ready_i = 0; mem_rdata_i = 0; settle();
        chk("t1_rvalid",   {31'd0, load_rvalid_o}, 1);
        chk("t1_rdata",    load_rdata_o, 32'hDEADBEEF);
        chk("t1_req_off",  {31'd0, mem_req_o}, 0);
        tick(); settle();
        chk("t1_rv_pulse", {31'd0, load_rvalid_o}, 0);
        chk("t1_rd_hold",  load_rdata_o, 32'hDEADBEEF);

        // 2: simultaneous requests -> store, load, fetch
        store_req_i = 1; store_addr_i = 32'h400; store_we_i = 4'b0011;
        store_data_i = 32'hCAFE0001;
        load_req_i = 1; load_addr_i = 32'h300;
        fetch_req_i = 1; fetch_addr_i = 32'h200; settle();
        chk("t2_gnt0", {29'd0, store_gnt_o, load_gnt_o, fetch_gnt_o}, 3'b100);
        tick();
        store_req_i = 0; mem_ready_i = 1; settle();
        chk("t2_st_addr",  mem_addr_o, 32'h400);
        chk("t2_st_we",    {28'd0, mem_we_o}, 4'b0011);
        chk("t2_st_wdata", mem_wdata_o, 32'hCAFE0001);
        tick();
        mem_ready_i = 0; settle();
        chk("t2_st_done", {31'd0, store_done_o}, 1);
        chk("t2_gnt1", {29'd0, store_gnt_o, load_gnt_o, fetch_gnt_o}, 3'b010);
        tick();
        load_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'h11111111; settle();
        chk("t2_ld_addr", mem_addr_o, 32'h300);
        chk("t2_ld_we",   {28'd0, mem_we_o}, 0);
        tick();
        mem_ready_i = 0; settle();
        chk("t2_ld_rdata", load_rdata_o, 32'h11111111);
        chk("t2_gnt2", {29'd0, store_gnt_o, load_gnt_o, fetch_gnt_o}, 3'b001);
        tick();
        fetch_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'h22222222; settle();
        chk("t2_f_addr", mem_addr_o, 32'h200);
        tick();
        mem_ready_i = 0; settle();
        chk("t2_f_rvalid", {31'd0, fetch_rvalid_o}, 1);
        chk("t2_f_rdata",  fetch_rdata_o, 32'h22222222);
        tick();

        // 3: starvation. Fetch held (except grant 6), load always asking.
        // Expected: fetch wins grants 5 and 11, load every other one.
        load_req_i = 1; load_addr_i = 32'h800; fetch_addr_i = 32'h900;
        for (int g = 1; g <= 11; g++) begin
            fetch_req_i = (g != 6); settle();
            chk($sformatf("t3_fgnt%0d", g), {31'd0, fetch_gnt_o}, (g == 5 || g == 11) ? 1 : 0);
            chk($sformatf("t3_lgnt%0d", g), {31'd0, load_gnt_o},  (g == 5 || g == 11) ? 0 : 1);
            tick();
            mem_ready_i = 1; settle();
            tick();
            mem_ready_i = 0;
        end
        load_req_i = 0; fetch_req_i = 0;
        tick();

        // 4a: timeout on fetch, ready never arrives
        fetch_req_i = 1; fetch_addr_i = 32'h500; settle();
        chk("t4_gnt", {31'd0, fetch_gnt_o}, 1);
        tick();
        fetch_req_i = 0; settle();
        cnt = 0;
        while (mem_req_o && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("t4_req_cycles", cnt, 16);
        chk("t4_timeout",    {31'd0, timeout_o}, 1);
        chk("t4_src",        {30'd0, timeout_src_o}, 2'd1);
        chk("t4_rvalid",     {31'd0, fetch_rvalid_o}, 1);
        chk("t4_rdata",      fetch_rdata_o, 0);
        tick();
        chk("t4_to_pulse",   {31'd0, timeout_o}, 0);

        // 4b: ready arrives in the last allowed cycle -> normal completion
        load_req_i = 1; load_addr_i = 32'h600; settle();
        tick();
        load_req_i = 0;
        for (int i = 0; i < 15; i++) tick();
        mem_ready_i = 1; mem_rdata_i = 32'h77; settle();
        chk("t4b_still_req", {31'd0, mem_req_o}, 1);
        tick();
        mem_ready_i = 0; mem_rdata_i = 0; settle();
        chk("t4b_rvalid",  {31'd0, load_rvalid_o}, 1);
        chk("t4b_rdata",   load_rdata_o, 32'h77);
        chk("t4b_no_to",   {31'd0, timeout_o}, 0);
        tick();

        // 5: reset in the middle of a long load
        load_req_i = 1; load_addr_i = 32'hA00; settle();
        tick();
        load_req_i = 0;
        tick(); tick();
        reset = 1;
        tick();
        reset = 0; settle();
        chk("t5_mem_req", {31'd0, mem_req_o}, 0);
        chk("t5_addr",    mem_addr_o, 0);
        chk("t5_rvalid",  {31'd0, load_rvalid_o}, 0);
        chk("t5_rdata",   load_rdata_o, 0);
        chk("t5_timeout", {31'd0, timeout_o}, 0);
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (load_rvalid_o || timeout_o || mem_req_o) pulses++;
        end
        chk("t5_quiet", pulses, 0);

        // 6: fetch withdraws while store is in flight
        store_req_i = 1; store_addr_i = 32'hB00; store_we_i = 4'b1111;
        store_data_i = 32'h12345678; fetch_req_i = 1; fetch_addr_i = 32'hC00; settle();
        chk("t6_st_gnt", {31'd0, store_gnt_o}, 1);
        tick();
        store_req_i = 0; fetch_req_i = 0; mem_ready_i = 1; settle();
        tick();
        mem_ready_i = 0; settle();
        chk("t6_done",    {31'd0, store_done_o}, 1);
        chk("t6_no_fgnt", {31'd0, fetch_gnt_o}, 0);
        chk("t6_req_lo",  {31'd0, mem_req_o}, 0);
        tick();
        chk("t6_req_lo2", {31'd0, mem_req_o}, 0);
        chk("t6_no_rv",   {31'd0, fetch_rvalid_o}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single external memory port among three requesters: instruction fetch, data load (issued from execute) and data store (issued from retire). Each transaction is granted, driven to memory and awaited, with a bounded wait. The block sits between the pipeline stages and the memory interface. It replaces the separate instruction and data ports when the core is built against a single-port RAM.

## Interface
Parameters:
- MAX_WAIT, default 15: maximum number of cycles in BUSY without `mem_ready_i` before the transaction is aborted. Legal range 1..255.
- STARVE_LIMIT, default 4: number of consecutive arbitration losses by fetch before fetch is promoted above load.

Ports. Reset is `reset`, synchronous, active-high; the clock is `clk`.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- fetch_req_i  in  1  fetch request; held until granted
- fetch_addr_i  in  32  fetch word address
- fetch_gnt_o  out  1  fetch granted this cycle
- fetch_rvalid_o  out  1  fetch data valid (1-cycle pulse)
- fetch_rdata_o  out  32  fetch read data
- load_req_i  in  1  load request
- load_addr_i  in  32  load address
- load_gnt_o  out  1  load granted this cycle
- load_rvalid_o  out  1  load data valid pulse
- load_rdata_o  out  32  load read data, full word
- store_req_i  in  1  store request
- store_addr_i  in  32  store address
- store_we_i  in  4  byte write enables; must be nonzero when store_req_i is high
- store_data_i  in  32  store data
- store_gnt_o  out  1  store granted this cycle
- store_done_o  out  1  store completed pulse
- mem_req_o  out  1  memory transaction active
- mem_addr_o  out  32  memory address
- mem_we_o  out  4  memory byte write enables; 0 for reads
- mem_wdata_o  out  32  memory write data
- mem_ready_i  in  1  memory completes the transaction this cycle
- mem_rdata_i  in  32  memory read data, valid with mem_ready_i
- timeout_o  out  1  abort pulse
- timeout_src_o  out  2  source of the aborted transaction; arbSrc_e encoding

## Operation
- The FSM has two states: IDLE and BUSY. Reset enters IDLE and clears all registers. Every output resets to 0.
- **IDLE:**
  - At most one `*_gnt_o` is asserted, combinationally, from the current requests.
  - Default priority is store > load > fetch.
  - When `starve_cnt == STARVE_LIMIT` and fetch is requesting, the order becomes store > fetch > load.
  - A grant latches the source, address, write enables and write data, then moves to BUSY.
- **starve_cnt** (saturating, 3 bits minimum):
  - Increments on each grant to load or store while fetch_req_i is high.
  - Clears on a fetch grant.
  - Store is never demoted. Store comes from retire and is already committed.
- **BUSY:**
  - `mem_req_o = 1`, driving the latched address, write enables and write data. No grants are issued.
  - `wait_cnt` starts at 0 and increments each cycle that `mem_ready_i` is low.
- **mem_ready_i high in BUSY:**
  - Capture `mem_rdata_i` into the source's rdata register.
  - Pulse the source's `rvalid_o`, or `store_done_o` for a store, on the next cycle.
  - Return to IDLE.
- **wait_cnt reaches MAX_WAIT with ready low:**
  - Drop `mem_req_o`, which aborts the transaction. Memory must discard it.
  - Next cycle: pulse `timeout_o` with `timeout_src_o` set, and pulse the source's rvalid/done with rdata = 0.
  - Return to IDLE.
- If `mem_ready_i` and the timeout condition occur in the same cycle, ready wins.
- Request lines and rdata outputs are independent per source. An rdata output holds its value until that source's next completion.
- A requester may drop its req after its grant. Dropping req before grant withdraws the request, which supports squashed fetches. A granted transaction always runs to completion.
- Reset in BUSY: IDLE on the next edge, `mem_req_o = 0`, and no rvalid, done or timeout pulse.

## Timing
- Request seen in cycle 0: gnt in cycle 0, `mem_req_o` in cycles 1..k, `mem_ready_i` in cycle k, rvalid/done in cycle k+1.
- Minimum latency, zero-wait memory: rvalid 2 cycles after req.
- The next grant can occur in cycle k+1, concurrently with the rvalid pulse. Back-to-back throughput is therefore one transaction per 2 cycles at zero wait.
- Timeout: with `mem_req_o` first high in cycle 1, the last cycle it is high is cycle MAX_WAIT+1. `timeout_o` pulses in cycle MAX_WAIT+2.
- Grant is combinational from the req inputs and the registered state. No other combinational path runs from inputs to outputs.

## Structure
- `my_pkg` holds:
  - `arbSrc_e` (2 bits): SRC_NONE = 0, SRC_FETCH = 1, SRC_LOAD = 2, SRC_STORE = 3.
  - `arbState_e`: IDLE, BUSY.
- One sub-module, `mem_arb_select`: a combinational priority picker. Inputs are the three reqs and the starve flag. Outputs are a one-hot grant and the `arbSrc_e` value.
- The top level holds the FSM, the latches, `wait_cnt`, `starve_cnt` and the response registers.

## Test plan
1. **Single load, zero-wait memory:** `load_req_i=1`, address 0x100, `mem_ready_i` in cycle 1 with rdata 0xDEADBEEF. Required: `load_gnt_o` in cycle 0, `mem_addr_o=0x100`, `mem_we_o=0`, `load_rvalid_o` in cycle 2 with `load_rdata_o=0xDEADBEEF`.
2. **Simultaneous requests:** store, load and fetch all requested in cycle 0. Required grant order is store, then load, then fetch. The store drives `mem_we_o=store_we_i` (e.g. 4'b0011) and `store_done_o` pulses after ready.
3. **Starvation:** fetch held high while load re-requests continuously, STARVE_LIMIT=4. Required: the 5th grant goes to fetch, then `starve_cnt` returns to 0.
4. **Timeout:** MAX_WAIT=15, `mem_ready_i` held low. Required: `mem_req_o` is high for 16 cycles, then `timeout_o=1`, `timeout_src_o=SRC_FETCH`, `fetch_rvalid_o=1` and `fetch_rdata_o=0`. Also verify that ready and timeout in the same cycle completes normally.
5. **Reset in BUSY:** reset asserted in cycle 3 of a 10-wait load. Required: all outputs 0 on the next cycle and no `load_rvalid_o`.
6. **Fetch withdrawal:** `fetch_req_i` dropped before grant while store is active. Required: no fetch grant and `mem_req_o` low after the store completes.
